// File: rtl/ad9434_spi_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ad9434_spi_master
// 3-wire SPI master for the AD9434 configuration port. Each transaction is a
// 24-bit frame: a 16-bit instruction followed by 8 data bits. On a write, all
// 24 bits are driven. On a read, the first 16 bits are driven, then SDIO is
// released and 8 bits are captured from the slave.
//
// Ports
//   clk, rst_n       system clock; asynchronous active-low reset
//   i_spi_wr_cmd     write request (level, sampled while idle)
//   i_spi_rd_cmd     read request  (level, sampled while idle)
//   i_spi_wr_data    write: {instr[15:0], data[7:0]}; read: instr in [15:0]
//   o_spi_rd_data    last completed read byte
//   o_spi_rd_valid   one-cycle pulse when o_spi_rd_data updates
//   o_spi_busy       transaction in progress
//   o_spi_csb        chip select, active low
//   o_spi_sclk       serial clock, idle low
//   o_spi_sdio_o     SDIO output data
//   o_spi_sdio_oe    SDIO drive enable (1 = drive)
//   i_spi_sdio_i     SDIO input data
// ---------------------------------------------------------------------------
module ad9434_spi_master #(
    parameter int unsigned MOSI_DATA_WIDTH = 24,
    parameter int unsigned MISO_DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_spi_wr_cmd,
    input  logic                       i_spi_rd_cmd,
    input  logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data,
    output logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data,
    output logic                       o_spi_rd_valid,
    output logic                       o_spi_busy,
    output logic                       o_spi_csb,
    output logic                       o_spi_sclk,
    output logic                       o_spi_sdio_o,
    output logic                       o_spi_sdio_oe,
    input  logic                       i_spi_sdio_i
);

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned DATA_W   = MOSI_DATA_WIDTH - INSTR_W;
    localparam logic [7:0]  HP_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0]  BIT_LAST = 5'(MOSI_DATA_WIDTH - 1);
    localparam logic [4:0]  RD_FIRST = 5'(INSTR_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SHIFT = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_e;

    // Sequencing state
    state_e                       state_q,   state_d;
    logic [7:0]                   hp_cnt_q,  hp_cnt_d;
    logic [4:0]                   bit_cnt_q, bit_cnt_d;
    logic                         phase_q,   phase_d;
    logic [MOSI_DATA_WIDTH-1:0]   shift_q,   shift_d;
    logic [MISO_DATA_WIDTH-1:0]   rx_q,      rx_d;
    logic                         is_read_q, is_read_d;

    // Registered outputs
    logic [MISO_DATA_WIDTH-1:0]   rd_data_q,  rd_data_d;
    logic                         rd_valid_q, rd_valid_d;
    logic                         busy_q,     busy_d;
    logic                         csb_q,      csb_d;
    logic                         sclk_q,     sclk_d;
    logic                         sdio_q,     sdio_d;
    logic                         oe_q,       oe_d;

    logic                         hp_done;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hp_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            phase_q    <= 1'b0;
            shift_q    <= '0;
            rx_q       <= '0;
            is_read_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            csb_q      <= 1'b1;
            sclk_q     <= 1'b0;
            sdio_q     <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_cnt_q   <= hp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            rx_q       <= rx_d;
            is_read_q  <= is_read_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            csb_q      <= csb_d;
            sclk_q     <= sclk_d;
            sdio_q     <= sdio_d;
            oe_q       <= oe_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        hp_cnt_d   = hp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        phase_d    = phase_q;
        shift_d    = shift_q;
        rx_d       = rx_q;
        is_read_d  = is_read_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        busy_d     = 1'b0;
        csb_d      = 1'b1;
        sclk_d     = 1'b0;
        sdio_d     = 1'b0;
        oe_d       = 1'b0;

        hp_done = (hp_cnt_q == HP_LAST);

        case (state_q)
            S_IDLE: begin
                // Write wins when both commands are present
                if (i_spi_wr_cmd || i_spi_rd_cmd) begin
                    state_d   = S_START;
                    hp_cnt_d  = '0;
                    bit_cnt_d = '0;
                    phase_d   = 1'b0;
                    is_read_d = !i_spi_wr_cmd;
                    if (i_spi_wr_cmd) begin
                        shift_d = i_spi_wr_data;
                    end else begin
                        shift_d = {i_spi_wr_data[INSTR_W-1:0], DATA_W'(0)};
                    end
                end
            end

            S_START: begin
                if (hp_done) begin
                    state_d  = S_SHIFT;
                    hp_cnt_d = '0;
                    phase_d  = 1'b0;
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end

            // phase_q = 0: sclk low half of a bit; phase_q = 1: sclk high half
            S_SHIFT: begin
                if (!hp_done) begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end else begin
                    hp_cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        // Capture read data on the cycle sclk rises
                        if (is_read_q && (bit_cnt_q >= RD_FIRST)) begin
                            rx_d = {rx_q[MISO_DATA_WIDTH-2:0], i_spi_sdio_i};
                        end
                    end else begin
                        phase_d = 1'b0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_STOP;
                            if (is_read_q) begin
                                rd_data_d  = rx_q;
                                rd_valid_d = 1'b1;
                            end
                        end else begin
                            // Advance data only on the falling edge of sclk
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            shift_d   = {shift_q[MOSI_DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end

            S_STOP: begin
                if (hp_done) begin
                    state_d  = S_GAP;
                    hp_cnt_d = '0;
                    phase_d  = 1'b0;
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end

            // Two half-period intervals with csb high before returning idle
            S_GAP: begin
                if (hp_done) begin
                    hp_cnt_d = '0;
                    if (phase_q) begin
                        state_d = S_IDLE;
                        phase_d = 1'b0;
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the upcoming state so they stay registered and aligned
        busy_d = (state_d != S_IDLE);
        csb_d  = !((state_d == S_START) || (state_d == S_SHIFT) || (state_d == S_STOP));
        sclk_d = (state_d == S_SHIFT) && phase_d;
        if ((state_d == S_START) || (state_d == S_SHIFT)) begin
            sdio_d = shift_d[MOSI_DATA_WIDTH-1];
        end
        if (state_d == S_START) begin
            oe_d = 1'b1;
        end else if (state_d == S_SHIFT) begin
            // Read releases SDIO from the falling edge that ends the instruction
            oe_d = !(is_read_d && (bit_cnt_d >= RD_FIRST));
        end else if (state_d == S_STOP) begin
            oe_d = !is_read_d;
        end
    end

    assign o_spi_rd_data  = rd_data_q;
    assign o_spi_rd_valid = rd_valid_q;
    assign o_spi_busy     = busy_q;
    assign o_spi_csb      = csb_q;
    assign o_spi_sclk     = sclk_q;
    assign o_spi_sdio_o   = sdio_q;
    assign o_spi_sdio_oe  = oe_q;

endmodule

// File: tb/tb_ad9434_spi_master.sv
`timescale 1ns/1ps
// Testbench for ad9434_spi_master: stimulus pushes expected frames into a
// queue; a bus monitor rebuilds each frame from the pins and checks it.
module tb_ad9434_spi_master;

    localparam int unsigned CLK_DIV = 4;

    typedef struct {
        logic        is_read;
        logic [23:0] word;
        logic [7:0]  sbyte;
        logic [7:0]  rd_after;
    } exp_t;

    exp_t exp_q[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_cmd = 1'b0;
    logic        rd_cmd = 1'b0;
    logic [23:0] wr_data = '0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        csb;
    logic        sclk;
    logic        sdio_o;
    logic        sdio_oe;
    logic        sdio_i = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_rd   = '0;
    logic [7:0] slave_byte = '0;
    int         fall_cnt   = 0;
    logic       s_prev_sclk = 1'b0;

    ad9434_spi_master #(
        .MOSI_DATA_WIDTH (24),
        .MISO_DATA_WIDTH (8),
        .CLK_DIV         (CLK_DIV)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_spi_wr_cmd   (wr_cmd),
        .i_spi_rd_cmd   (rd_cmd),
        .i_spi_wr_data  (wr_data),
        .o_spi_rd_data  (rd_data),
        .o_spi_rd_valid (rd_valid),
        .o_spi_busy     (busy),
        .o_spi_csb      (csb),
        .o_spi_sclk     (sclk),
        .o_spi_sdio_o   (sdio_o),
        .o_spi_sdio_oe  (sdio_oe),
        .i_spi_sdio_i   (sdio_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic lvl);
        int n;
        n = 0;
        while (busy !== lvl && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: actual=%0b required=%0b", busy, lvl);
        end
    endtask

    // Slave: shifts its byte out on bits 16..23, changing after each sclk fall
    always @(posedge clk) begin
        #1;
        if (csb) fall_cnt = 0;
        else if (s_prev_sclk && !sclk) fall_cnt++;
        s_prev_sclk = sclk;
        if (!csb && fall_cnt >= 16 && fall_cnt <= 23) sdio_i = slave_byte[3'(23 - fall_cnt)];
        else sdio_i = 1'($urandom);
    end

    // Monitor: reconstruct each transaction from the pins
    logic        m_active = 1'b0;
    logic        p_busy = 1'b0, p_sclk = 1'b0, p_csb = 1'b1, p_sdio = 1'b0, p_oe = 1'b0;
    int          m_busy_cnt, m_csb_low, m_rises, m_viol, m_vcnt, m_vpos;
    logic [23:0] m_mosi, m_oe;
    logic [7:0]  m_vdata;

    task automatic check_txn();
        exp_t e;
        logic [23:0] act_mosi, req_mosi;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_txn: actual=1 required=0");
            return;
        end
        e = exp_q.pop_front();
        req_mosi = e.is_read ? {e.word[15:0], 8'h00} : e.word;
        act_mosi = e.is_read ? {m_mosi[23:8], 8'h00} : m_mosi;
        chk("mosi_bits", 32'(act_mosi), 32'(req_mosi));
        chk("oe_on_rises", 32'(m_oe), e.is_read ? 32'h00FFFF00 : 32'h00FFFFFF);
        chk("sclk_rises", 32'(m_rises), 32'd24);
        chk("csb_low_len", 32'(m_csb_low), 32'(50 * CLK_DIV));
        chk("busy_len", 32'(m_busy_cnt), 32'((2 * 24 + 4) * CLK_DIV));
        chk("sdio_change_off_fall", 32'(m_viol), 32'd0);
        chk("rd_valid_count", 32'(m_vcnt), e.is_read ? 32'd1 : 32'd0);
        if (e.is_read) begin
            chk("rd_valid_pos", 32'(m_vpos), 32'(49 * CLK_DIV + 1));
            chk("rd_valid_data", 32'(m_vdata), 32'(e.sbyte));
        end
        chk("rd_data_hold", 32'(rd_data), 32'(e.rd_after));
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            m_active = 1'b0;
            p_busy = 1'b0; p_sclk = 1'b0; p_csb = 1'b1; p_sdio = 1'b0; p_oe = 1'b0;
        end else begin
            if (busy && !p_busy) begin
                m_active = 1'b1;
                m_busy_cnt = 0; m_csb_low = 0; m_rises = 0; m_viol = 0;
                m_vcnt = 0; m_vpos = 0; m_mosi = '0; m_oe = '0; m_vdata = '0;
            end
            if (m_active && busy) begin
                m_busy_cnt++;
                if (!csb) m_csb_low++;
                if (sclk && !p_sclk) begin
                    m_mosi = {m_mosi[22:0], sdio_o};
                    m_oe   = {m_oe[22:0], sdio_oe};
                    m_rises++;
                end
                if (!csb && !p_csb && sdio_oe && p_oe && (sdio_o !== p_sdio) && !(p_sclk && !sclk))
                    m_viol++;
                if (rd_valid) begin
                    m_vcnt++;
                    m_vpos = m_csb_low;
                    m_vdata = rd_data;
                end
            end
            if (m_active && !busy && p_busy) begin
                m_active = 1'b0;
                check_txn();
            end
            p_busy = busy; p_sclk = sclk; p_csb = csb; p_sdio = sdio_o; p_oe = sdio_oe;
        end
    end

    // Issue one command for a single cycle and record its expected frame
    task automatic do_txn(input logic wr, input logic rd, input logic [23:0] data, input logic [7:0] sb);
        exp_t e;
        wait_busy(1'b0);
        @(negedge clk);
        slave_byte = sb;
        if (!wr) model_rd = sb;
        e.is_read  = !wr;
        e.word     = data;
        e.sbyte    = sb;
        e.rd_after = model_rd;
        exp_q.push_back(e);
        wr_cmd  = wr;
        rd_cmd  = rd;
        wr_data = data;
        @(negedge clk);
        wr_cmd  = 1'b0;
        rd_cmd  = 1'b0;
        wr_data = 24'($urandom);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int gap;
        int sclk_hi;
        int n;
        int k;
        exp_t e;

        #1 rst_n = 1'b0;
        repeat (3) step();
        chk("reset_csb", 32'(csb), 32'd1);
        chk("reset_sclk", 32'(sclk), 32'd0);
        chk("reset_sdio_o", 32'(sdio_o), 32'd0);
        chk("reset_sdio_oe", 32'(sdio_oe), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();

        // Directed write and read
        do_txn(1'b1, 1'b0, 24'h000F08, 8'h00);
        wait_busy(1'b0);
        do_txn(1'b0, 1'b1, 24'h008001, 8'h6A);
        wait_busy(1'b0);

        // Both commands: write wins, no read completion
        do_txn(1'b1, 1'b1, 24'h002A03, 8'h55);
        wait_busy(1'b0);

        // Read request during a write is ignored
        do_txn(1'b1, 1'b0, 24'h0123C4, 8'h00);
        repeat (60) @(negedge clk);
        rd_cmd = 1'b1;
        @(negedge clk);
        rd_cmd = 1'b0;
        wait_busy(1'b0);
        repeat (20) step();

        // Random mix
        for (int i = 0; i < 10; i++) begin
            k = int'($urandom_range(0, 2));
            do_txn(k != 1, k != 0, 24'($urandom), 8'($urandom));
            wait_busy(1'b0);
            repeat ($urandom_range(0, 5)) step();
        end

        // Write command held across two transactions
        wait_busy(1'b0);
        @(negedge clk);
        e.is_read  = 1'b0;
        e.word     = 24'h00A55A;
        e.sbyte    = 8'h00;
        e.rd_after = model_rd;
        exp_q.push_back(e);
        exp_q.push_back(e);
        wr_data = 24'h00A55A;
        wr_cmd  = 1'b1;
        n = 0;
        while (csb !== 1'b0 && n < 50) begin step(); n++; end
        while (csb !== 1'b1 && n < 500) begin step(); n++; end
        gap = 0;
        while (csb !== 1'b0 && gap < 50) begin step(); gap++; end
        chk("csb_gap_held_cmd", 32'(gap), 32'(2 * CLK_DIV + 1));
        @(negedge clk);
        wr_cmd = 1'b0;
        wait_busy(1'b0);
        repeat (5) step();

        // Reset during bit 10 of a write aborts it immediately
        do_txn(1'b1, 1'b0, 24'h5A5A5A, 8'h00);
        n = 0;
        while (fall_cnt != 10 && n < 400) begin step(); n++; end
        step();
        #2 rst_n = 1'b0;
        exp_q.delete();
        model_rd = 8'h00;
        #1;
        chk("abort_csb", 32'(csb), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_oe", 32'(sdio_oe), 32'd0);
        chk("abort_rd_data", 32'(rd_data), 32'd0);
        sclk_hi = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (sclk) sclk_hi++;
        end
        chk("abort_sclk_quiet", 32'(sclk_hi), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();
        do_txn(1'b1, 1'b0, 24'h00FF01, 8'h00);
        wait_busy(1'b0);
        do_txn(1'b0, 1'b1, 24'h00C3D2, 8'h81);
        wait_busy(1'b0);

        repeat (50) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
